// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
//   div_state_t : divider FSM states
//   DIV_ITER    : number of restoring iterations for a 32-bit divide
//   abs32       : two's-complement magnitude; 0x80000000 maps to itself,
//                 which is the correct unsigned magnitude
package mdu_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    localparam int unsigned DIV_ITER = 32;

    function automatic logic [31:0] abs32(input logic [31:0] value);
        return value[31] ? -value : value;
    endfunction

endpackage

// File: rtl/mdu_divider_div_step.sv
// One restoring-division iteration, purely combinational.
//   rem_in   : partial remainder (always < divisor)
//   quo_in   : remaining dividend bits / quotient bits built so far
//   divisor  : divisor magnitude
//   rem_out  : next partial remainder
//   quo_out  : next quotient word (new bit shifted in at the LSB)
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    // One extra bit so the trial subtraction's sign is visible. Because
    // rem_in < divisor, shifted < 2*divisor and the top bit of diff is set
    // exactly when the subtraction would go negative.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        rem_out = shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_out = diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_divider.sv
// Iterative DIV/DIVU unit for the execute stage.
// Produces {HI, LO} = {remainder, quotient} 33 cycles after start is taken.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request a division (only honoured while idle)
//   cancel     : flush/exception abort; wins over start and suppresses done
//   is_signed  : 1 = DIV, 0 = DIVU
//   dividend   : rs operand
//   divisor    : rt operand
//   busy       : stall request while an operation is in flight (RUN/DONE)
//   done       : one-cycle result-valid pulse
//   hilo_we    : HI/LO write enable, identical to done
//   hilo_out   : {remainder, quotient}; updated only when entering DONE
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = DIV_ITER   // must equal WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cancel,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic                 hilo_we,
    output logic [2*WIDTH-1:0]   hilo_out
);

    localparam int unsigned CNT_W = $clog2(ITER);

    div_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    rem;
    logic [WIDTH-1:0]    quo;
    logic [WIDTH-1:0]    dvs;
    logic [WIDTH-1:0]    orig_dividend;
    logic                neg_quo;
    logic                neg_rem;
    logic                div_zero;
    logic                busy_q;
    logic                done_q;
    logic                hilo_we_q;

    logic [WIDTH-1:0]    rem_nxt;
    logic [WIDTH-1:0]    quo_nxt;
    logic [WIDTH-1:0]    rem_fix;
    logic [WIDTH-1:0]    quo_fix;
    logic                last_step;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    assign last_step = (cnt == CNT_W'(ITER - 1));

    // Sign fix-up on the final step's output. Magnitudes were divided, so
    // the quotient takes the XOR of the signs and the remainder the sign of
    // the dividend. Divide-by-zero overrides with the architected values.
    always_comb begin
        quo_fix = neg_quo ? -quo_nxt : quo_nxt;
        rem_fix = neg_rem ? -rem_nxt : rem_nxt;
        if (div_zero) begin
            quo_fix = '1;
            rem_fix = orig_dividend;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= DIV_IDLE;
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            orig_dividend <= '0;
            neg_quo       <= 1'b0;
            neg_rem       <= 1'b0;
            div_zero      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            hilo_we_q     <= 1'b0;
            hilo_out      <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    done_q    <= 1'b0;
                    hilo_we_q <= 1'b0;
                    if (start && !cancel) begin
                        state         <= DIV_RUN;
                        busy_q        <= 1'b1;
                        cnt           <= '0;
                        rem           <= '0;
                        quo           <= is_signed ? abs32(dividend) : dividend;
                        dvs           <= is_signed ? abs32(divisor) : divisor;
                        orig_dividend <= dividend;
                        neg_quo       <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem       <= is_signed && dividend[WIDTH-1];
                        div_zero      <= (divisor == '0);
                    end
                end

                DIV_RUN: begin
                    if (cancel) begin
                        state  <= DIV_IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (last_step) begin
                            state     <= DIV_DONE;
                            done_q    <= 1'b1;
                            hilo_we_q <= 1'b1;
                            hilo_out  <= {rem_fix, quo_fix};
                        end
                    end
                end

                DIV_DONE: begin
                    state     <= DIV_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    hilo_we_q <= 1'b0;
                    cnt       <= '0;
                end

                default: begin
                    state     <= DIV_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    hilo_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    // A flush arriving in the DONE cycle must still block the HI/LO write.
    assign done    = done_q && !cancel;
    assign hilo_we = hilo_we_q && !cancel;

endmodule
